// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to NUM_REQ requesters,
// clearing it, running it to the winner's target length and pulsing done.
module counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    input  logic [CNT_W-1:0]         cnt_value,
    output logic                     cnt_reset,
    output logic                     cnt_enable,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [1:0]               state_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Handshake: req is a level held by the requester until it sees its done bit;
    // dropping it while granted (before DONE) aborts the job without a done pulse.

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [CNT_W-1:0] pick_len;
    logic [NUM_REQ-1:0] win_onehot;

    // Scan starts just past the previous winner and wraps around.
    always_comb begin : pick
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!pick_found && req[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign pick_len = len[pick_idx*CNT_W +: CNT_W];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    win_d   = pick_idx;
                    tgt_d   = pick_len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (!req[win_q]) begin
                    state_d = IDLE;
                    last_d  = win_q;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!req[win_q]) begin
                    state_d = IDLE;
                    last_d  = win_q;
                end else if (cnt_value == tgt_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                last_d  = win_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            win_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            tgt_q   <= tgt_d;
        end
    end

    // Enable drops on the cycle the counter reaches the target, so it never wraps.
    assign win_onehot = NUM_REQ'(1) << win_q;
    assign busy       = (state_q != IDLE);
    assign gnt        = busy ? win_onehot : '0;
    assign done       = (state_q == DONE) ? win_onehot : '0;
    assign cnt_reset  = (state_q == CLEAR);
    assign cnt_enable = (state_q == RUN) && (cnt_value != tgt_q);
    assign state_o    = state_q;

endmodule
